// File: rtl/alu_operand_stage_if.sv
// ALU operation encoding and the bundled decode/forwarding/ALU-facing signals
// of the ID/EX operand stage.

package alu_operand_stage_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

interface alu_operand_stage_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
);
  import alu_operand_stage_pkg::*;

  logic              stall;
  logic              flush;
  logic              id_valid;
  aluop_t            id_aluop;
  logic [WORD_W-1:0] id_rdat1;
  logic [WORD_W-1:0] id_rdat2;
  logic [WORD_W-1:0] id_imm;
  logic [4:0]        id_shamt;
  logic [1:0]        id_alusrc;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_wsel;
  logic              id_regwen;
  logic              exmem_regwen;
  logic [REG_W-1:0]  exmem_wsel;
  logic [WORD_W-1:0] exmem_wdat;
  logic              memwb_regwen;
  logic [REG_W-1:0]  memwb_wsel;
  logic [WORD_W-1:0] memwb_wdat;

  logic              ex_valid;
  aluop_t            ALUOP;
  logic [WORD_W-1:0] porta;
  logic [WORD_W-1:0] portb;
  logic [WORD_W-1:0] ex_storedat;
  logic [REG_W-1:0]  ex_wsel;
  logic              ex_regwen;

  // Upstream side (decode, hazard unit, later pipeline stages) drives master.
  modport master (
    output stall, flush, id_valid, id_aluop, id_rdat1, id_rdat2, id_imm,
           id_shamt, id_alusrc, id_rs, id_rt, id_wsel, id_regwen,
           exmem_regwen, exmem_wsel, exmem_wdat,
           memwb_regwen, memwb_wsel, memwb_wdat,
    input  ex_valid, ALUOP, porta, portb, ex_storedat, ex_wsel, ex_regwen
  );

  modport slave (
    input  stall, flush, id_valid, id_aluop, id_rdat1, id_rdat2, id_imm,
           id_shamt, id_alusrc, id_rs, id_rt, id_wsel, id_regwen,
           exmem_regwen, exmem_wsel, exmem_wdat,
           memwb_regwen, memwb_wsel, memwb_wdat,
    output ex_valid, ALUOP, porta, portb, ex_storedat, ex_wsel, ex_regwen
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding and ALU operand
// selection. Flush beats stall beats load; a stall keeps refreshing rs/rt data.

module alu_operand_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input logic               CLK,
  input logic               nRST,
  alu_operand_stage_if.slave bus
);
  import alu_operand_stage_pkg::*;

  logic              valid_q,  valid_d;
  aluop_t            aluop_q,  aluop_d;
  logic [WORD_W-1:0] rdat1_q,  rdat1_d;
  logic [WORD_W-1:0] rdat2_q,  rdat2_d;
  logic [WORD_W-1:0] imm_q,    imm_d;
  logic [4:0]        shamt_q,  shamt_d;
  logic [1:0]        alusrc_q, alusrc_d;
  logic [REG_W-1:0]  rs_q,     rs_d;
  logic [REG_W-1:0]  rt_q,     rt_d;
  logic [REG_W-1:0]  wsel_q,   wsel_d;
  logic              regwen_q, regwen_d;

  logic [WORD_W-1:0] fwd_a;
  logic [WORD_W-1:0] fwd_b;
  logic [WORD_W-1:0] porta_c;
  logic [WORD_W-1:0] portb_c;
  logic [WORD_W-1:0] shamt_ext;

  assign shamt_ext = {{(WORD_W-5){1'b0}}, shamt_q};

  // EX/MEM is the younger writer and wins; register 0 is hardwired zero.
  always_comb begin
    fwd_a = rdat1_q;
    if (bus.exmem_regwen && (bus.exmem_wsel == rs_q) && (rs_q != '0))
      fwd_a = bus.exmem_wdat;
    else if (bus.memwb_regwen && (bus.memwb_wsel == rs_q) && (rs_q != '0))
      fwd_a = bus.memwb_wdat;

    fwd_b = rdat2_q;
    if (bus.exmem_regwen && (bus.exmem_wsel == rt_q) && (rt_q != '0))
      fwd_b = bus.exmem_wdat;
    else if (bus.memwb_regwen && (bus.memwb_wsel == rt_q) && (rt_q != '0))
      fwd_b = bus.memwb_wdat;
  end

  always_comb begin
    porta_c = fwd_a;
    portb_c = fwd_b;
    case (alusrc_q)
      2'b01: portb_c = imm_q;
      2'b10: begin
        porta_c = fwd_b;
        portb_c = shamt_ext;
      end
      default: ;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    aluop_d  = aluop_q;
    rdat1_d  = rdat1_q;
    rdat2_d  = rdat2_q;
    imm_d    = imm_q;
    shamt_d  = shamt_q;
    alusrc_d = alusrc_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    wsel_d   = wsel_q;
    regwen_d = regwen_q;
    if (bus.flush) begin
      valid_d  = 1'b0;
      aluop_d  = ALU_SLL;
      rdat1_d  = '0;
      rdat2_d  = '0;
      imm_d    = '0;
      shamt_d  = '0;
      alusrc_d = '0;
      rs_d     = '0;
      rt_d     = '0;
      wsel_d   = '0;
      regwen_d = 1'b0;
    end else if (bus.stall) begin
      // A writer may retire while we wait; capture its value so it survives.
      rdat1_d = fwd_a;
      rdat2_d = fwd_b;
    end else begin
      valid_d  = bus.id_valid;
      aluop_d  = bus.id_aluop;
      rdat1_d  = bus.id_rdat1;
      rdat2_d  = bus.id_rdat2;
      imm_d    = bus.id_imm;
      shamt_d  = bus.id_shamt;
      alusrc_d = bus.id_alusrc;
      rs_d     = bus.id_rs;
      rt_d     = bus.id_rt;
      wsel_d   = bus.id_wsel;
      regwen_d = bus.id_regwen & bus.id_valid;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q  <= 1'b0;
      aluop_q  <= ALU_SLL;
      rdat1_q  <= '0;
      rdat2_q  <= '0;
      imm_q    <= '0;
      shamt_q  <= '0;
      alusrc_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      wsel_q   <= '0;
      regwen_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      aluop_q  <= aluop_d;
      rdat1_q  <= rdat1_d;
      rdat2_q  <= rdat2_d;
      imm_q    <= imm_d;
      shamt_q  <= shamt_d;
      alusrc_q <= alusrc_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      wsel_q   <= wsel_d;
      regwen_q <= regwen_d;
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ALUOP       = aluop_q;
  assign bus.porta       = porta_c;
  assign bus.portb       = portb_c;
  assign bus.ex_storedat = fwd_b;
  assign bus.ex_wsel     = wsel_q;
  assign bus.ex_regwen   = regwen_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and randomized checks of alu_operand_stage against a behavioural
// model of what the stage holds and what the ALU should see.

module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  localparam int OUT_W = 1 + 4 + 32 + 32 + 32 + 5 + 1;

  typedef struct packed {
    logic        valid;
    logic [3:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [1:0]  src;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wsel;
    logic        wen;
  } stage_t;

  logic clk;
  logic nrst;
  int   checks;
  int   failures;
  stage_t m;
  stage_t nxt;
  logic [OUT_W-1:0] exp_q[$];

  alu_operand_stage_if #(.WORD_W(32), .REG_W(5)) ifc ();

  alu_operand_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (ifc.slave)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- reference model ----
  function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] held);
    logic        wen [2];
    logic [4:0]  sel [2];
    logic [31:0] dat [2];
    wen[0] = ifc.exmem_regwen; sel[0] = ifc.exmem_wsel; dat[0] = ifc.exmem_wdat;
    wen[1] = ifc.memwb_regwen; sel[1] = ifc.memwb_wsel; dat[1] = ifc.memwb_wdat;
    for (int i = 0; i < 2; i++)
      if (wen[i] && sel[i] == r && r != 5'd0) return dat[i];
    return held;
  endfunction

  function automatic stage_t model_next(input stage_t cur);
    stage_t s;
    s = cur;
    if (ifc.flush) begin
      s = '0;
    end else if (ifc.stall) begin
      s.a = resolve(cur.rs, cur.a);
      s.b = resolve(cur.rt, cur.b);
    end else begin
      s.valid = ifc.id_valid;
      s.aluop = ifc.id_aluop;
      s.a     = ifc.id_rdat1;
      s.b     = ifc.id_rdat2;
      s.imm   = ifc.id_imm;
      s.shamt = ifc.id_shamt;
      s.src   = ifc.id_alusrc;
      s.rs    = ifc.id_rs;
      s.rt    = ifc.id_rt;
      s.wsel  = ifc.id_wsel;
      s.wen   = ifc.id_regwen && ifc.id_valid;
    end
    return s;
  endfunction

  function automatic logic [OUT_W-1:0] model_out(input stage_t s);
    logic [31:0] fa, fb, pa, pb;
    fa = resolve(s.rs, s.a);
    fb = resolve(s.rt, s.b);
    pa = fa;
    pb = fb;
    if (s.src == 2'b01) pb = s.imm;
    if (s.src == 2'b10) begin
      pa = fb;
      pb = 32'(s.shamt);
    end
    return {s.valid, s.aluop, pa, pb, fb, s.wsel, s.wen};
  endfunction

  function automatic logic [OUT_W-1:0] dut_out();
    return {ifc.ex_valid, ifc.ALUOP, ifc.porta, ifc.portb, ifc.ex_storedat,
            ifc.ex_wsel, ifc.ex_regwen};
  endfunction

  // ---- scoreboard ----
  task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                       input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic tick();
    nxt = model_next(m);
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  task automatic set_writers(input logic ew, input logic [4:0] es, input logic [31:0] ed,
                             input logic mw, input logic [4:0] ms, input logic [31:0] md);
    ifc.exmem_regwen = ew; ifc.exmem_wsel = es; ifc.exmem_wdat = ed;
    ifc.memwb_regwen = mw; ifc.memwb_wsel = ms; ifc.memwb_wdat = md;
  endtask

  task automatic set_instr(input aluop_t op, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] imm, input logic [4:0] sh, input logic [1:0] src,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ws);
    ifc.id_valid = 1'b1; ifc.id_regwen = 1'b1;
    ifc.id_aluop = op; ifc.id_rdat1 = r1; ifc.id_rdat2 = r2; ifc.id_imm = imm;
    ifc.id_shamt = sh; ifc.id_alusrc = src; ifc.id_rs = rs; ifc.id_rt = rt; ifc.id_wsel = ws;
  endtask

  task automatic randomize_inputs();
    ifc.stall = ($urandom_range(0, 3) == 0);
    ifc.flush = ($urandom_range(0, 9) == 0);
    ifc.id_valid = 1'($urandom_range(0, 1));
    ifc.id_regwen = 1'($urandom_range(0, 1));
    ifc.id_aluop = aluop_t'(4'($urandom_range(0, 9)));
    ifc.id_rdat1 = $urandom; ifc.id_rdat2 = $urandom; ifc.id_imm = $urandom;
    ifc.id_shamt = 5'($urandom_range(0, 31));
    ifc.id_alusrc = 2'($urandom_range(0, 3));
    ifc.id_rs = 5'($urandom_range(0, 3));
    ifc.id_rt = 5'($urandom_range(0, 3));
    ifc.id_wsel = 5'($urandom_range(0, 31));
    set_writers(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
  endtask

  initial begin
    logic [OUT_W-1:0] e;
    checks = 0;
    failures = 0;
    m = '0;
    nrst = 1'b0;
    ifc.stall = 1'b0; ifc.flush = 1'b0; ifc.id_valid = 1'b0; ifc.id_regwen = 1'b0;
    ifc.id_aluop = ALU_SLL; ifc.id_rdat1 = '0; ifc.id_rdat2 = '0; ifc.id_imm = '0;
    ifc.id_shamt = '0; ifc.id_alusrc = '0; ifc.id_rs = '0; ifc.id_rt = '0; ifc.id_wsel = '0;
    set_writers(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_out(), '0);
    @(negedge clk);
    nrst = 1'b1;

    // Reset asserted between edges clears everything at once
    set_instr(ALU_ADD, 32'd5, 32'd7, 32'd0, 5'd0, 2'b00, 5'd1, 5'd2, 5'd3);
    tick();
    check("midop_loaded", dut_out(), model_out(m));
    check("midop_porta", 107'(ifc.porta), 107'(32'd5));
    #2 nrst = 1'b0;
    #1 m = '0;
    check("async_reset", dut_out(), '0);
    #2 nrst = 1'b1;

    // Plain immediate load
    set_instr(ALU_ADD, 32'h10, 32'h0, 32'hFFFF_FFF0, 5'd0, 2'b01, 5'd1, 5'd2, 5'd3);
    tick();
    check("load_porta", 107'(ifc.porta), 107'(32'h10));
    check("load_portb", 107'(ifc.portb), 107'(32'hFFFF_FFF0));
    check("load_valid", 107'(ifc.ex_valid), 107'(1'b1));
    check("load_model", dut_out(), model_out(m));

    // Forward priority: EX/MEM over MEM/WB
    set_instr(ALU_OR, 32'h1, 32'h2, 32'h0, 5'd0, 2'b00, 5'd3, 5'd2, 5'd6);
    set_writers(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    tick();
    check("fwd_exmem", 107'(ifc.porta), 107'(32'hAA));
    ifc.exmem_regwen = 1'b0;
    #1;
    check("fwd_memwb", 107'(ifc.porta), 107'(32'hBB));
    check("fwd_model", dut_out(), model_out(m));

    // Register zero is never forwarded
    set_instr(ALU_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 5'd0, 5'd0, 5'd1);
    set_writers(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
    tick();
    check("zero_reg", 107'(ifc.porta), 107'(32'h0));
    check("zero_model", dut_out(), model_out(m));

    // Stall capture of a retiring MEM/WB writer
    set_writers(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_instr(ALU_SUB, 32'h0, 32'h1, 32'h0, 5'd0, 2'b00, 5'd0, 5'd4, 5'd7);
    tick();
    check("stall_pre", 107'(ifc.portb), 107'(32'h1));
    ifc.stall = 1'b1;
    set_writers(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h99);
    tick();
    ifc.memwb_regwen = 1'b0;
    #1;
    check("stall_cap_portb", 107'(ifc.portb), 107'(32'h99));
    check("stall_cap_store", 107'(ifc.ex_storedat), 107'(32'h99));
    tick();
    check("stall_hold_model", dut_out(), model_out(m));
    ifc.stall = 1'b0;
    #1;
    check("stall_drop_portb", 107'(ifc.portb), 107'(32'h99));
    check("stall_drop_store", 107'(ifc.ex_storedat), 107'(32'h99));

    // Flush wins over stall
    ifc.stall = 1'b1;
    ifc.flush = 1'b1;
    tick();
    check("flush_valid", 107'(ifc.ex_valid), 107'(1'b0));
    check("flush_regwen", 107'(ifc.ex_regwen), 107'(1'b0));
    check("flush_aluop", 107'(ifc.ALUOP), 107'(ALU_SLL));
    check("flush_bubble", dut_out(), '0);
    ifc.stall = 1'b0;
    ifc.flush = 1'b0;

    // Shift: value on A, amount on B
    set_instr(ALU_SLL, 32'h0, 32'h8000_0000, 32'h0, 5'd4, 2'b10, 5'd0, 5'd5, 5'd8);
    tick();
    check("shift_porta", 107'(ifc.porta), 107'(32'h8000_0000));
    check("shift_portb", 107'(ifc.portb), 107'(32'd4));
    check("shift_model", dut_out(), model_out(m));

    // Randomized traffic through the expected-value queue
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      randomize_inputs();
      nxt = model_next(m);
      exp_q.push_back(model_out(nxt));
      @(posedge clk);
      m = nxt;
      #1;
      e = exp_q.pop_front();
      check($sformatf("rand_%0d", i), dut_out(), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
